// File: rtl/nonce_select_if.sv
// ---------------------------------------------------------------------------
// nonce_select_if
//
// Purpose:
//   Memory bus between nonce_select and the single-port synchronous memory
//   that it shares with the SHA-256 hasher.
//
// Signals:
//   mem_clk         memory clock (a copy of the system clock)
//   mem_we          write enable
//   mem_addr        word address (registered by the master)
//   mem_write_data  write data (registered by the master)
//   mem_read_data   read data; the word addressed at one rising edge is
//                   valid after that edge and captured on the next one
//
// Modports:
//   master  used by nonce_select (drives address/write side)
//   slave   used by the memory (returns read data)
// ---------------------------------------------------------------------------
interface nonce_select_if;

   logic        mem_clk;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   modport master (
      output mem_clk,
      output mem_we,
      output mem_addr,
      output mem_write_data,
      input  mem_read_data
   );

   modport slave (
      input  mem_clk,
      input  mem_we,
      input  mem_addr,
      input  mem_write_data,
      output mem_read_data
   );

endinterface

// File: rtl/nonce_select.sv
// ---------------------------------------------------------------------------
// nonce_select
//
// Purpose:
//   Downstream stage of the 16-nonce SHA-256 hasher. After a start pulse it
//   streams NUM_NONCES hash words out of shared memory, tracks the
//   numerically smallest one, compares it against a difficulty target and
//   writes a two-word result record back to memory:
//     word 0 = {found, best_nonce zero-extended to 31 bits}
//     word 1 = best_hash
//   then raises done, which stays high until the next accepted start.
//
// Parameters:
//   NUM_NONCES  number of consecutive hash words scanned (1..256)
//   NONCE_W     width of best_nonce; 2**NONCE_W >= NUM_NONCES
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        begin a scan (only honoured in IDLE)
//   hash_addr    address of the hash word for nonce 0
//   result_addr  address of the two-word result record
//   target       unsigned difficulty threshold
//   done         scan and write-back complete
//   found        best_hash < target
//   best_nonce   index of the minimum hash
//   best_hash    minimum hash value
//   mem          memory bus (master side)
// ---------------------------------------------------------------------------
module nonce_select #(
   parameter int NUM_NONCES = 16,
   parameter int NONCE_W    = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [15:0]         hash_addr,
   input  logic [15:0]         result_addr,
   input  logic [31:0]         target,
   output logic                done,
   output logic                found,
   output logic [NONCE_W-1:0]  best_nonce,
   output logic [31:0]         best_hash,
   nonce_select_if.master      mem
);

   // Nine bits cover every count from 0 up to the largest legal NUM_NONCES.
   localparam int CNT_W = 9;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      WR0,
      WR1,
      FIN
   } state_t;

   state_t              state_q,     state_d;
   logic [CNT_W-1:0]    issueCnt_q,  issueCnt_d;
   logic [CNT_W-1:0]    readCnt_q,   readCnt_d;
   logic                primed_q,    primed_d;
   logic [15:0]         baseAddr_q,  baseAddr_d;
   logic [15:0]         resAddr_q,   resAddr_d;
   logic [31:0]         target_q,    target_d;
   logic                done_q,      done_d;
   logic                found_q,     found_d;
   logic [NONCE_W-1:0]  bestNonce_q, bestNonce_d;
   logic [31:0]         bestHash_q,  bestHash_d;
   logic                memWe_q,     memWe_d;
   logic [15:0]         memAddr_q,   memAddr_d;
   logic [31:0]         memWdata_q,  memWdata_d;
   logic                foundNext;

   // The memory runs off the same clock; all bus outputs come straight from
   // registers so the memory sees clean, glitch-free address and data.
   assign mem.mem_clk        = clk;
   assign mem.mem_we         = memWe_q;
   assign mem.mem_addr       = memAddr_q;
   assign mem.mem_write_data = memWdata_q;

   assign done       = done_q;
   assign found      = found_q;
   assign best_nonce = bestNonce_q;
   assign best_hash  = bestHash_q;

   // State register. An asserted reset clears everything at once, including
   // the write enable, so an interrupted write-back can never land in memory.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         issueCnt_q  <= '0;
         readCnt_q   <= '0;
         primed_q    <= 1'b0;
         baseAddr_q  <= '0;
         resAddr_q   <= '0;
         target_q    <= '0;
         done_q      <= 1'b0;
         found_q     <= 1'b0;
         bestNonce_q <= '0;
         bestHash_q  <= '0;
         memWe_q     <= 1'b0;
         memAddr_q   <= '0;
         memWdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         issueCnt_q  <= issueCnt_d;
         readCnt_q   <= readCnt_d;
         primed_q    <= primed_d;
         baseAddr_q  <= baseAddr_d;
         resAddr_q   <= resAddr_d;
         target_q    <= target_d;
         done_q      <= done_d;
         found_q     <= found_d;
         bestNonce_q <= bestNonce_d;
         bestHash_q  <= bestHash_d;
         memWe_q     <= memWe_d;
         memAddr_q   <= memAddr_d;
         memWdata_q  <= memWdata_d;
      end
   end

   // The hit decision is made from the final registered minimum, one cycle
   // after the last compare, so it never depends on the live read path.
   assign foundNext = (bestHash_q < target_q);

   // Next-state and datapath logic. Every register holds its value unless a
   // state explicitly updates it.
   //
   // SCAN overlaps two activities: issuing addresses back to back, and
   // comparing the words that come back two edges later. The issue side runs
   // ahead by one address (address 0 goes out on the start edge). The
   // compare side waits one idle cycle (primed_q) for the first word to make
   // its way through the memory, then consumes one word per cycle.
   //
   // The base addresses and target are captured at start so that the caller
   // may change its inputs while a scan is in flight.
   always_comb begin
      state_d     = state_q;
      issueCnt_d  = issueCnt_q;
      readCnt_d   = readCnt_q;
      primed_d    = primed_q;
      baseAddr_d  = baseAddr_q;
      resAddr_d   = resAddr_q;
      target_d    = target_q;
      done_d      = done_q;
      found_d     = found_q;
      bestNonce_d = bestNonce_q;
      bestHash_d  = bestHash_q;
      memWe_d     = memWe_q;
      memAddr_d   = memAddr_q;
      memWdata_d  = memWdata_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               memAddr_d   = hash_addr;
               memWe_d     = 1'b0;
               done_d      = 1'b0;
               bestHash_d  = 32'hFFFF_FFFF;
               bestNonce_d = '0;
               found_d     = 1'b0;
               readCnt_d   = '0;
               issueCnt_d  = CNT_W'(1);
               primed_d    = 1'b0;
               baseAddr_d  = hash_addr;
               resAddr_d   = result_addr;
               target_d    = target;
               state_d     = SCAN;
            end
         end

         SCAN: begin
            if (issueCnt_q < CNT_W'(NUM_NONCES)) begin
               // 16-bit add wraps naturally past 16'hFFFF.
               memAddr_d  = baseAddr_q + 16'(issueCnt_q);
               issueCnt_d = issueCnt_q + CNT_W'(1);
            end

            if (!primed_q) begin
               primed_d = 1'b1;
            end else begin
               // Strict compare so that ties keep the earlier nonce.
               if (mem.mem_read_data < bestHash_q) begin
                  bestHash_d  = mem.mem_read_data;
                  bestNonce_d = NONCE_W'(readCnt_q);
               end
               readCnt_d = readCnt_q + CNT_W'(1);
               if (readCnt_q == CNT_W'(NUM_NONCES - 1)) begin
                  state_d = WR0;
               end
            end
         end

         WR0: begin
            memWe_d    = 1'b1;
            memAddr_d  = resAddr_q;
            memWdata_d = {foundNext, 31'(bestNonce_q)};
            found_d    = foundNext;
            state_d    = WR1;
         end

         WR1: begin
            memWe_d    = 1'b1;
            memAddr_d  = resAddr_q + 16'd1;
            memWdata_d = bestHash_q;
            state_d    = FIN;
         end

         FIN: begin
            memWe_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: doc/nonce_select.md
Name: nonce_select

Overview:
- Downstream stage of the 16-nonce SHA-256 hasher.
- After the hasher asserts done, this block reads the per-nonce hash words from shared memory, starting at the hasher's output_addr.
- It finds the numerically smallest hash and checks it against a difficulty target.
- It writes a two-word result record back to memory and flags completion. It shares the same single-port synchronous memory interface as the hasher.

Parameters:
- NUM_NONCES, 16, number of consecutive hash words scanned (valid range 1..256).
- NONCE_W, 4, width of the nonce index output; must satisfy 2**NONCE_W >= NUM_NONCES.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin scan; sampled in IDLE only.
- hash_addr  in  16  base address of hash word for nonce 0; nonce i is at hash_addr+i.
- result_addr  in  16  base address of the two-word result record.
- target  in  32  difficulty threshold, unsigned.
- done  out  1  scan and write-back complete; held until the next accepted start.
- found  out  1  best_hash < target.
- best_nonce  out  NONCE_W  index of the minimum hash.
- best_hash  out  32  minimum hash value.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address (registered).
- mem_write_data  out  32  memory write data (registered).
- mem_read_data  in  32  memory read data.

Behaviour:
- Reset (any time, including mid-scan): state=IDLE; done=0, found=0, best_nonce=0, best_hash=0, mem_we=0, mem_addr=0, mem_write_data=0. No partial write may complete after reset asserts.
- Memory timing: the memory samples mem_addr on a rising edge. Data is captured by this block on the following rising edge, i.e. two edges after mem_addr was registered.
- States: IDLE, SCAN, WR0, WR1, FIN.
- IDLE, start=1 at edge E0:
  - mem_addr<=hash_addr, mem_we<=0, done<=0.
  - best_hash<=32'hFFFFFFFF, best_nonce<=0, found<=0.
  - Read counter<=0, issue counter<=1. Go to SCAN.
- SCAN, address issue: while issue counter < NUM_NONCES, mem_addr<=hash_addr+issue counter each cycle, so addresses are back-to-back.
- SCAN, compare: from edge E2, capture mem_read_data as word i = read counter, once per cycle.
  - If word < best_hash (unsigned, strict), then best_hash<=word and best_nonce<=i.
  - Ties keep the lower index.
- SCAN exit: after the compare of word NUM_NONCES-1 (edge E(NUM_NONCES+1)), go to WR0.
- WR0 (edge E(NUM_NONCES+2)):
  - mem_we<=1, mem_addr<=result_addr.
  - mem_write_data<={found_next, zero-extended best_nonce to 31 bits}, where found_next=(best_hash<target).
  - found<=found_next.
- WR1 (edge E(NUM_NONCES+3)): mem_we<=1, mem_addr<=result_addr+1, mem_write_data<=best_hash.
- FIN (edge E(NUM_NONCES+4)): mem_we<=0, done<=1, go to IDLE.
- Latency: done rises at edge E(NUM_NONCES+4), which is 20 cycles after start for the default.
- done stays 1 in IDLE until the next accepted start clears it.
- start while not in IDLE is ignored; no restart and no queueing.
- start held high continuously: a new scan is accepted on the first IDLE cycle after FIN.
- Address arithmetic is 16-bit and wraps modulo 2**16 (e.g. hash_addr=16'hFFFF reads FFFF, 0000, ...).
- target=0: found is always 0.
- All hashes 32'hFFFFFFFF: best_hash=FFFFFFFF, best_nonce=0, found=(target>FFFFFFFF)=0.
- mem_we is 1 only in the two write cycles.

Test Plan:
- Basic minimum: hashes = 1000-i for i=0..15, target=1000 → best_nonce=15, best_hash=985, found=1. Record {32'h8000000F, 32'd985} written at result_addr; done at cycle 20.
- No hit: hashes all ≥ 32'h00010000 with a minimum of 32'h00010000 at nonce 7, target=32'h00010000 (strict compare) → found=0, best_nonce=7, word0=32'h00000007.
- Tie: nonces 3 and 9 both hold 32'h00000005 as the minimum, target=32'hFFFFFFFF → best_nonce=3, best_hash=5, found=1.
- Reset mid-scan: assert reset_n=0 at cycle 8 → all outputs 0 next cycle, no memory write observed. A new start then completes normally with the correct result.
- Busy start: pulse start again at cycles 3 and 18 → ignored; only one record written; done rises at cycle 20 and stays high until the next start.
- Address wrap: hash_addr=16'hFFF8 → reads FFF8..FFFF then 0000..0007; result matches the reference model.
